// File: rtl/patch_extractor.sv
// Patch responder: holds a 4x4 image and gathers a 3x3 patch one pixel per cycle on request.
// Optional macro PATCH_EXTRACTOR_ZERO_PAD_EN zero-pads elements that fall outside the image.
module patch_extractor #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                img_we,
    input  logic [3:0]          img_waddr,
    input  logic [DATA_W-1:0]   img_wdata,
    input  logic                req,
    input  logic [3:0]          pixel_addr,
    output logic [9*DATA_W-1:0] patch,
    output logic                patch_valid,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    // Handshake: req is a level held by the requester until it has seen the one-cycle
    // patch_valid pulse; a request is only accepted from IDLE, so a held req never refetches.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_VALID    = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_k;
    logic [1:0]          r_r0;
    logic [1:0]          r_c0;
    logic [9*DATA_W-1:0] r_patch;
    logic [DATA_W-1:0]   r_img [16];

    logic [1:0]          w_i;
    logic [3:0]          w_j_full;
    logic [2:0]          w_row;
    logic [2:0]          w_col;
    logic [4:0]          w_lin;
    logic [3:0]          w_addr;
    logic [DATA_W-1:0]   w_pix;

    // Element address: i = k/3, j = k%3, row/col sums kept at 3 bits.
    always_comb begin
        w_i = 2'd0;
        if (r_k >= 4'd6) begin
            w_i = 2'd2;
        end else if (r_k >= 4'd3) begin
            w_i = 2'd1;
        end
        w_j_full = r_k - {1'b0, w_i, 1'b0} - {2'b00, w_i};
        w_row    = {1'b0, r_r0} + {1'b0, w_i};
        w_col    = {1'b0, r_c0} + {1'b0, w_j_full[1:0]};
        w_lin    = {w_row, 2'b00} + {2'b00, w_col};
        w_addr   = w_lin[3:0];
        w_pix    = r_img[w_addr];
`ifdef PATCH_EXTRACTOR_ZERO_PAD_EN
        if ((w_row > 3'd3) || (w_col > 3'd3)) begin
            w_pix = '0;
        end
`endif
    end

    // Register file reads the pre-write value in the same cycle as a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 16; n++) begin
                r_img[n] <= '0;
            end
        end else if (img_we) begin
            r_img[img_waddr] <= img_wdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (req) w_next = S_FETCH;
            S_FETCH:    if (r_k == 4'd8) w_next = S_VALID;
            S_VALID:    w_next = S_WAIT_REL;
            S_WAIT_REL: if (!req) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= 4'd0;
            r_r0    <= 2'd0;
            r_c0    <= 2'd0;
            r_patch <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && req) begin
                r_r0 <= pixel_addr[3:2];
                r_c0 <= pixel_addr[1:0];
                r_k  <= 4'd0;
            end else if (r_state == S_FETCH) begin
                for (int e = 0; e < 9; e++) begin
                    if (r_k == 4'(e)) begin
                        r_patch[e*DATA_W +: DATA_W] <= w_pix;
                    end
                end
                r_k <= r_k + 4'd1;
            end
        end
    end

    assign patch       = r_patch;
    assign patch_valid = (r_state == S_VALID);
    assign busy        = (r_state != S_IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_patch_extractor.sv
// Bench for patch_extractor: directed requests, expected patches queued and checked by a monitor.
module tb_patch_extractor;

    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic           img_we;
    logic [3:0]     img_waddr;
    logic [W-1:0]   img_wdata;
    logic           req;
    logic [3:0]     pixel_addr;
    logic [9*W-1:0] patch;
    logic           patch_valid;
    logic           busy;
    logic [1:0]     dbg_state;

    logic [9*W-1:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;
    int n_pulses = 0;

    patch_extractor #(.DATA_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .img_we     (img_we),
        .img_waddr  (img_waddr),
        .img_wdata  (img_wdata),
        .req        (req),
        .pixel_addr (pixel_addr),
        .patch      (patch),
        .patch_valid(patch_valid),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input logic [9*W-1:0] act,
                       input logic [9*W-1:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [9*W-1:0] pk(input int e0, input int e1, input int e2,
                                          input int e3, input int e4, input int e5,
                                          input int e6, input int e7, input int e8);
        return {W'(e8), W'(e7), W'(e6), W'(e5), W'(e4), W'(e3), W'(e2), W'(e1), W'(e0)};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && patch_valid) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_valid", patch, '0);
            end else begin
                logic [9*W-1:0] e;
                e = exp_q.pop_front();
                chk(patch === e, "patch", patch, e);
            end
        end
    end

    task automatic load_img();
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            img_we = 1'b1; img_waddr = 4'(n); img_wdata = W'(n + 1);
        end
        @(posedge clk); #1;
        img_we = 1'b0;
    endtask

    // Issue one request. wr_edge>0 writes wa/wd sampled at edge E(wr_edge).
    task automatic do_req(input logic [3:0] addr, input logic [9*W-1:0] exp, input int hold,
                          input int wr_edge, input logic [3:0] wa, input logic [W-1:0] wd);
        int  cnt;
        bit  found;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        pixel_addr = addr; req = 1'b1;
        @(posedge clk);
        #1;
        pixel_addr = ~addr;
        img_we = (wr_edge == 1); img_waddr = wa; img_wdata = wd;
        cnt = 0; found = 1'b0;
        while (cnt < 30) begin
            @(negedge clk);
            if (patch_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); cnt++; #1;
            img_we = (cnt + 1 == wr_edge); img_waddr = wa; img_wdata = wd;
        end
        img_we = 1'b0;
        // valid is visible in the cycle after E9, i.e. first sampled at E10
        chk(found && cnt == 9, "latency", 72'(cnt), 72'd9);
        if (hold == 0) begin
            req = 1'b0;
            @(posedge clk); @(negedge clk);
            chk(busy === 1'b1, "busy_wait_rel", 72'(busy), 72'd1);
            @(posedge clk); @(negedge clk);
            chk(busy === 1'b0, "busy_release", 72'(busy), 72'd0);
        end else begin
            repeat (hold) @(posedge clk);
            #1 req = 1'b0;
            repeat (2) @(negedge clk);
            chk(busy === 1'b0, "busy_after_hold", 72'(busy), 72'd0);
        end
    endtask

    logic [9*W-1:0] p_a0;
    int p_before;

    initial begin
        reset = 1'b1; img_we = 1'b0; img_waddr = '0; img_wdata = '0;
        req = 1'b0; pixel_addr = '0;
        #1;
        chk(patch === '0, "reset_patch", patch, '0);
        chk(patch_valid === 1'b0, "reset_valid", 72'(patch_valid), 72'd0);
        chk(busy === 1'b0, "reset_busy", 72'(busy), 72'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        load_img();
        p_a0 = pk(1, 2, 3, 5, 6, 7, 9, 10, 11);
        do_req(4'd0, p_a0, 0, 0, 4'd0, '0);
        do_req(4'd5, pk(6, 7, 8, 10, 11, 12, 14, 15, 16), 0, 0, 4'd0, '0);
`ifdef PATCH_EXTRACTOR_ZERO_PAD_EN
        do_req(4'd3, pk(4, 0, 0, 8, 0, 0, 12, 0, 0), 0, 0, 4'd0, '0);
        do_req(4'd15, pk(16, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 4'd0, '0);
`else
        do_req(4'd3, pk(4, 5, 6, 8, 9, 10, 12, 13, 14), 0, 0, 4'd0, '0);
        do_req(4'd15, pk(16, 1, 2, 4, 5, 6, 8, 9, 10), 0, 0, 4'd0, '0);
`endif

        // held request yields one pulse only, then a fresh request works
        p_before = n_pulses;
        do_req(4'd0, p_a0, 20, 0, 4'd0, '0);
        chk(n_pulses - p_before == 1, "single_pulse", 72'(n_pulses - p_before), 72'd1);
        do_req(4'd5, pk(6, 7, 8, 10, 11, 12, 14, 15, 16), 0, 0, 4'd0, '0);

        // write to image[0] at E3 of a fetch: captured element stays old
        do_req(4'd0, p_a0, 0, 3, 4'd0, 8'hAA);
        do_req(4'd0, pk(8'hAA, 2, 3, 5, 6, 7, 9, 10, 11), 0, 0, 4'd0, '0);

        // reset at E5 of a fetch aborts and clears the image
        @(posedge clk); #1;
        pixel_addr = 4'd0; req = 1'b1;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk(patch === '0, "abort_patch", patch, '0);
        chk(patch_valid === 1'b0, "abort_valid", 72'(patch_valid), 72'd0);
        chk(busy === 1'b0, "abort_busy", 72'(busy), 72'd0);
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        do_req(4'd0, '0, 0, 0, 4'd0, '0);
        load_img();
        do_req(4'd0, p_a0, 0, 0, 4'd0, '0);

        repeat (5) @(posedge clk);
        chk(exp_q.size() == 0, "queue_drained", 72'(exp_q.size()), 72'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/patch_extractor.md
# patch_extractor

Responder side of the controller's patch handshake. Holds the 4×4 input image in an internal 16-entry register file, loaded through a write port. On a request carrying a top-left pixel address, it gathers the 3×3 patch anchored there, one pixel per cycle. It then presents the patch to the convolution stage and pulses `patch_valid` back to the controller FSM.

## Interface
- `DATA_W`, default 8: pixel width in bits.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `img_we`  in  1  image write enable.
- `img_waddr`  in  4  image write address, row*4+col.
- `img_wdata`  in  DATA_W  image write data.
- `req`  in  1  patch request level (driven by `load_conv`); held high until `patch_valid` is seen.
- `pixel_addr`  in  4  patch top-left address; `[3:2]`=row, `[1:0]`=col.
- `patch`  out  9*DATA_W  patch, element k=i*3+j at `[k*DATA_W +: DATA_W]`.
- `patch_valid`  out  1  single-cycle completion pulse.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, FETCH, VALID, WAIT_REL.
- IDLE:
  - When `req`=1 at a rising edge, latch `pixel_addr` as base row r0 / col c0.
  - Clear element counter k to 0 and go to FETCH.
- FETCH:
  - Each cycle, compute i=k/3, j=k%3, and read image[(r0+i)*4+(c0+j)] combinationally from the register file.
  - Write the result into `patch` element k at the next edge and increment k.
  - After capturing k=8, go to VALID.
- VALID: `patch_valid`=1 for exactly this cycle, then go to WAIT_REL.
- WAIT_REL:
  - Stay while `req`=1.
  - Go to IDLE on `req`=0.
  - A held `req` never triggers a second fetch.
- Address arithmetic:
  - r0+i and c0+j are each 3-bit sums (range 0..5).
  - Out-of-image handling is set by the configuration macro.
- `patch` holds its value from VALID until the first capture of the next fetch. It is not cleared between fetches.
- Image writes are accepted in every state.
  - The register file is read-before-write: a same-cycle read of the address being written returns the old value.
  - Elements already captured are unaffected by later writes.
- `pixel_addr` is sampled only in IDLE. Changes during FETCH are ignored.
- The module never uses `kernel_sel`; kernel choice belongs to the conv stage.

## Timing
- Reset (async, immediate):
  - State IDLE, k=0.
  - `patch`=0, `patch_valid`=0, `busy`=0.
  - All 16 image entries = 0.
- Let E0 be the edge that samples `req`=1 in IDLE:
  - `busy` rises after E0.
  - Element k is captured at edge E(k+1).
  - `patch_valid` is high in the cycle after E9, so it is first sampled high at E10.
  - Latency is 10 cycles request-to-valid.
- Minimum turnaround:
  - `req` falls at E11, the first edge after the VALID cycle, so WAIT_REL → IDLE at E11.
  - A new `req` can be sampled at E12.
- Reset asserted mid-FETCH or mid-VALID aborts with no `patch_valid` pulse and clears the image. After release, a fresh request behaves normally.
- `req` dropping during FETCH does not abort. The fetch completes and `patch_valid` still pulses; WAIT_REL then exits on the first edge.

## Configuration
- Macro `PATCH_EXTRACTOR_ZERO_PAD_EN`.
- Defined: any element with r0+i>3 or c0+j>3 reads as 0. This is zero padding at the image edge.
- Undefined: the element address is ((r0+i)*4+(c0+j)) mod 16, truncated to 4 bits, and the image is read there. No padding logic is present.

## Test plan
- Load image[n]=n+1; request addr 0 → `patch`={1,2,3,5,6,7,9,10,11}, `patch_valid` sampled high only at E10, `busy` low at E11 after `req` drops.
- Same image, addr 5 → {6,7,8,10,11,12,14,15,16}.
- Addr 3:
  - with macro → {4,0,0,8,0,0,12,0,0};
  - without macro → {4,5,6,8,9,10,12,13,14}.
- Hold `req` high 20 cycles after `patch_valid` → exactly one pulse; drop then re-raise `req` → second pulse 10 cycles later.
- Assert `reset` at E5 of a fetch → `patch`=0, `patch_valid`=0, `busy`=0 immediately; reload image, request addr 0 → correct patch at E10.
- During a fetch of addr 0, write image[0]=0xAA at E3 → captured element 0 stays 1; next fetch returns 0xAA in element 0.
